aes_round_sched: RTL and testbench
==================================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, SHALL set the number of round iterations per block (AES-128).
REQ-002 Port clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst  in  1  SHALL be the asynchronous active-low reset (asserted when 0).
REQ-004 Ports req0_valid/req1_valid  in  1 each  SHALL be request-valid per requester.
REQ-005 Ports req0_ready/req1_ready  out  1 each  SHALL be the per-requester accept strobes.
REQ-006 Ports req0_key/req1_key  in  128 each  SHALL be the cipher key per requester.
REQ-007 Ports req0_data/req1_data  in  128 each  SHALL be the plaintext per requester.
REQ-008 Ports rsp_valid  out  1, rsp_id  out  1, rsp_data  out  128, rsp_ready  in  1  SHALL form the result handshake.
REQ-009 Ports rnd_state, rnd_key  out  128 each, rnd_rcon  out  8, rnd_final  out  1 SHALL drive the shared external round unit.
REQ-010 Ports rnd_state_nxt, rnd_key_nxt  in  128 each SHALL be the round unit's combinational results.
REQ-011 Port busy  out  1 SHALL be high whenever the FSM is not IDLE.

Function
REQ-012 FSM SHALL have states IDLE, ROUND, HOLD.
REQ-013 In IDLE, reqN_ready SHALL be high only for the granted requester; both readys low outside IDLE.
REQ-014 Arbitration SHALL be round-robin: both valid -> grant the requester not served last; one valid -> grant it.
REQ-015 On accept (valid & ready), state reg <= data ^ key, key reg <= key, round counter <= 1, rcon <= 0x01, id <= granted index, last_grant <= index; FSM -> ROUND.
REQ-016 In ROUND, each cycle state reg <= rnd_state_nxt, key reg <= rnd_key_nxt, counter +1, rcon <= xtime(rcon) (0x80 -> 0x1b).
REQ-017 rnd_state/rnd_key/rnd_rcon SHALL mirror state reg/key reg/rcon reg; rnd_final high iff ROUND and counter == NUM_ROUNDS.
REQ-018 On the ROUND cycle with counter == NUM_ROUNDS, FSM -> HOLD; rsp_valid high from next cycle, i.e. NUM_ROUNDS cycles after the accept edge.
REQ-019 In HOLD, rsp_valid, rsp_id, rsp_data (state reg) SHALL stay stable until rsp_ready; on rsp_valid & rsp_ready FSM -> IDLE.
REQ-020 No request SHALL be accepted in the cycle of the response handshake; earliest next accept is one cycle after.
REQ-021 Request inputs SHALL be ignored outside IDLE; requesters hold valid/key/data until ready.
REQ-022 Counter width SHALL be 4 bits; rcon arithmetic is 8-bit GF(2^8) xtime.

Reset
REQ-023 rst low SHALL immediately force IDLE, rsp_valid=0, rsp_id=0, busy=0, both readys reflect IDLE arbitration only after release.
REQ-024 Reset SHALL clear state reg, key reg, counter, rcon to 0 and set last_grant=1 so req0 wins the first tie.
REQ-025 Reset mid-ROUND or mid-HOLD SHALL discard the block; no response is produced for it.

Structure
REQ-026 A shared package aes_sched_pkg SHALL hold the FSM state enum, AES_NR=10, RCON_INIT=8'h01, RCON_WRAP=8'h1b.
REQ-027 A single sub-module aes_rr_arb (2-way round-robin grant with last_grant pointer) SHALL be used; round unit stays external.

Verification
REQ-028 req0 key 000102..0f, data 00112233445566778899aabbccddeeff, reference round unit -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_valid 10 cycles after accept.
REQ-029 req0 and req1 valid same cycle after reset -> req0 served first, then req1; rsp_id sequence 0,1.
REQ-030 rsp_ready held low 5 cycles in HOLD -> rsp_valid/rsp_data stable, both readys low, busy=1.
REQ-031 Monitor rnd_rcon over one block -> 01,02,04,08,10,20,40,80,1b,36; rnd_final only on the tenth ROUND cycle.
REQ-032 rst low during round 5 -> outputs reset asynchronously; after release a new request completes correctly with no stale response.
REQ-033 Continuous req1 valid with req0 valid -> grants alternate 1,0,1,0 after first tie; neither starves.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared FSM states, AES-128 round constants and xtime helper.
package aes_sched_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_t;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_WRAP = 8'h1b;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_WRAP : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rr_arb.sv
// aes_rr_arb: 2-way round-robin grant; ties go to the requester not served last.
module aes_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       take,
  output logic [1:0] grant,
  output logic       idx
);
  logic last;
  assign idx = valid[1] & (~valid[0] | ~last);
  assign grant = valid == 2'b00 ? 2'b00 : (idx ? 2'b10 : 2'b01);
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= 1'b1;
    else if (take) last <= idx;
endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: arbitrates two AES-128 requesters and sequences rounds
// through an external combinational round unit.
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  input  logic [127:0] req0_data,
  input  logic [127:0] req1_data,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  input  logic         rsp_ready,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [7:0]   rnd_rcon,
  output logic         rnd_final,
  input  logic [127:0] rnd_state_nxt,
  input  logic [127:0] rnd_key_nxt,
  output logic         busy
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  state_t fsm;
  logic [127:0] st, ky;
  logic [3:0] cnt;
  logic [7:0] rc;
  logic id, idx, take, idle;
  logic [1:0] grant;
  aes_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .valid({req1_valid, req0_valid}),
    .take (take),
    .grant(grant),
    .idx  (idx)
  );
  // readys are held low while reset is asserted, even though the FSM sits in IDLE
  assign idle = rst && fsm == IDLE;
  assign take = idle && |grant;
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign rnd_state = st;
  assign rnd_key = ky;
  assign rnd_rcon = rc;
  assign rnd_final = fsm == ROUND && cnt == LAST;
  assign rsp_valid = fsm == HOLD;
  assign rsp_id = id;
  assign rsp_data = st;
  assign busy = fsm != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsm <= IDLE;
      st  <= '0;
      ky  <= '0;
      cnt <= '0;
      rc  <= '0;
      id  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (take) begin
          st  <= idx ? req1_data ^ req1_key : req0_data ^ req0_key;
          ky  <= idx ? req1_key : req0_key;
          cnt <= 4'd1;
          rc  <= RCON_INIT;
          id  <= idx;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= rnd_state_nxt;
          ky  <= rnd_key_nxt;
          cnt <= cnt + 4'd1;
          rc  <= xtime(rc);
          fsm <= cnt == LAST ? HOLD : ROUND;
        end
        HOLD: if (rsp_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: reference AES round unit plus a block-level model of
// arbitration, latency and ciphertext checked every cycle.
module tb_aes_round_sched;
  localparam int NR = 10;
  typedef struct {logic [127:0] k; logic [127:0] d;} req_t;
  logic clk = 0, rst, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] req0_key, req1_key, req0_data, req1_data, rsp_data;
  logic rsp_valid, rsp_id, rsp_ready, rnd_final, busy;
  logic [127:0] rnd_state, rnd_key, rnd_state_nxt, rnd_key_nxt;
  logic [7:0] rnd_rcon;
  int vectors = 0, errs = 0;
  req_t q0[$], q1[$];
  logic hist[$];
  logic [127:0] last_data;
  int cyc = 0, acc = 0, lat = 0, fin = 0;
  logic pv = 0;
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_round_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_key(req0_key), .req1_key(req1_key),
    .req0_data(req0_data), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_rcon(rnd_rcon), .rnd_final(rnd_final),
    .rnd_state_nxt(rnd_state_nxt), .rnd_key_nxt(rnd_key_nxt), .busy(busy)
  );

  function automatic logic [7:0] m2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ x;
      x = m2(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01, b = x, e = 8'd254, v;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return v;
  endfunction
  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] rk, input logic fin_r);
    logic [7:0] a [16], b [16];
    logic [7:0] x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
      a[4*c]   = fin_r ? x0 : m2(x0) ^ m2(x1) ^ x1 ^ x2 ^ x3;
      a[4*c+1] = fin_r ? x1 : x0 ^ m2(x1) ^ m2(x2) ^ x2 ^ x3;
      a[4*c+2] = fin_r ? x2 : x0 ^ x1 ^ m2(x2) ^ m2(x3) ^ x3;
      a[4*c+3] = fin_r ? x3 : m2(x0) ^ x0 ^ x1 ^ x2 ^ m2(x3);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] d);
    logic [127:0] s = d ^ k, rk = k;
    logic [7:0] rc = 8'h01;
    for (int r = 1; r <= NR; r++) begin
      rk = kexp(rk, rc);
      s = aes_rnd(s, rk, r == NR);
      rc = m2(rc);
    end
    return s;
  endfunction

  always_comb begin
    rnd_key_nxt = kexp(rnd_key, rnd_rcon);
    rnd_state_nxt = aes_rnd(rnd_state, rnd_key_nxt, rnd_final);
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // block-level model: whole-block ciphertext and a cycle timer since accept
  logic m_busy = 0, m_id = 0, m_last = 1, g0, g1;
  int m_timer = 0;
  logic [127:0] m_exp = '0;
  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 0; m_last = 1; m_timer = 0;
      chk("reset_outs", 128'({busy, rsp_valid, rsp_id, req0_ready, req1_ready}), 128'd0);
    end else if (!m_busy) begin
      g0 = req0_valid & (~req1_valid | m_last);
      g1 = req1_valid & ~g0;
      chk("ready", 128'({req0_ready, req1_ready}), 128'({g0, g1}));
      chk("idle_outs", 128'({busy, rsp_valid}), 128'd0);
      if (g0 | g1) begin
        m_busy = 1; m_timer = 0; m_id = g1; m_last = g1;
        m_exp = g1 ? aes_enc(req1_key, req1_data) : aes_enc(req0_key, req0_data);
      end
    end else begin
      chk("busy_outs", 128'({busy, req0_ready, req1_ready}), 128'b100);
      chk("rsp_valid", 128'(rsp_valid), 128'(m_timer >= NR));
      if (m_timer >= NR) begin
        chk("rsp_id", 128'(rsp_id), 128'(m_id));
        chk("rsp_data", rsp_data, m_exp);
        if (rsp_ready) m_busy = 0;
      end else begin
        chk("rcon", 128'(rnd_rcon), 128'(rc_tab[m_timer]));
        chk("final", 128'(rnd_final), 128'(m_timer == NR - 1));
        m_timer++;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) pv = 0;
    else begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc = cyc;
      if (rsp_valid && !pv) lat = cyc - acc - 1;
      if (rnd_final) fin++;
      if (rsp_valid && rsp_ready) begin
        hist.push_back(rsp_id);
        last_data = rsp_data;
      end
      pv = rsp_valid;
    end
  end

  task automatic drive();
    req0_valid = q0.size() > 0;
    req1_valid = q1.size() > 0;
    req0_key = req0_valid ? q0[0].k : '0;
    req0_data = req0_valid ? q0[0].d : '0;
    req1_key = req1_valid ? q1[0].k : '0;
    req1_data = req1_valid ? q1[0].d : '0;
  endtask
  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive();
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < lim) begin
      step();
      n++;
    end
    vectors++;
    if (n >= lim) begin
      errs++;
      $display("FAIL timeout: still busy after %0d cycles", n);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h, n;
    logic [127:0] d0;
    rst = 0; rsp_ready = 1;
    drive();
    chk("model_kexp_r1", kexp(FK, 8'h01), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_fips", aes_enc(FK, FD), FC);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
    // FIPS-197 vector on req0
    fin = 0; h = hist.size();
    q0.push_back('{FK, FD}); drive();
    wait_done(100);
    chk("fips_latency", 128'(lat), 128'd10);
    chk("fips_final_cnt", 128'(fin), 128'd1);
    chk("fips_cnt", 128'(hist.size()), 128'(h + 1));
    chk("fips_id", 128'(hist[h]), 128'd0);
    chk("fips_data", last_data, FC);
    // tie after reset: req0 then req1
    do_reset();
    h = hist.size();
    q0.push_back('{128'h11, 128'h22}); q1.push_back('{128'h33, 128'h44}); drive();
    wait_done(100);
    chk("tie_cnt", 128'(hist.size()), 128'(h + 2));
    chk("tie_id0", 128'(hist[h]), 128'd0);
    chk("tie_id1", 128'(hist[h+1]), 128'd1);
    // both requesters continuously valid: strict alternation
    do_reset();
    h = hist.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{128'(i) ^ FK, 128'(i * 7)});
      q1.push_back('{~FK, FD + 128'(i)});
    end
    drive();
    wait_done(300);
    chk("alt_cnt", 128'(hist.size()), 128'(h + 6));
    for (int i = 0; i < 6; i++) chk("alt_id", 128'(hist[h+i]), 128'(i % 2));
    // stalled response with the other requester waiting
    rsp_ready = 0;
    q0.push_back('{128'hdeadbeef, 128'hcafef00d}); drive();
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk("hold_reached", 128'(rsp_valid), 128'd1);
    q1.push_back('{128'h5, 128'h6}); drive();
    d0 = rsp_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_stable", rsp_data, d0);
      chk("hold_flags", 128'({rsp_valid, busy, req0_ready, req1_ready}), 128'b1100);
    end
    rsp_ready = 1;
    wait_done(100);
    // reset during round 5 discards the block
    q0.push_back('{128'h77, 128'h88}); drive();
    n = 0;
    while (q0.size() > 0 && n < 20) begin step(); n++; end
    repeat (4) step();
    h = hist.size();
    #2 rst = 0;
    #1;
    chk("async_rst", 128'({busy, rsp_valid, rsp_id}), 128'd0);
    chk("async_rst_state", rnd_state, 128'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
    q1.push_back('{FK, FD}); drive();
    wait_done(100);
    chk("post_rst_cnt", 128'(hist.size()), 128'(h + 1));
    chk("post_rst_id", 128'(hist[h]), 128'd1);
    chk("post_rst_data", last_data, FC);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
